// File: rtl/spmv_pkg.sv
// Shared definitions for the CSR SpMV datapath.
//   SPMV_DATA_W : operand/sum width (fixed by carry_select_adder)
//   SPMV_ROW_W  : default row index width
//   acc_state_t : row accumulator output-register state
package spmv_pkg;

    localparam int unsigned SPMV_DATA_W = 16;
    localparam int unsigned SPMV_ROW_W  = 16;

    typedef enum logic {
        S_ACC = 1'b0,   // output register empty
        S_OUT = 1'b1    // output register holds a result
    } acc_state_t;

endpackage

// File: rtl/carry_select_adder.sv
// 16-bit carry-select adder: four 4-bit blocks, each upper block precomputes
// both carry-in cases and selects on the incoming block carry.
// Ports:
//   a, b      in  16  operands
//   carryin   in  1   carry into bit 0
//   s         out 16  sum (combinational)
//   carryout  out 1   carry out of bit 15 (combinational)
module carry_select_adder
    import spmv_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryin,
    output logic [15:0] s,
    output logic        carryout
);

    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = 4;

    logic [N_BLK:0] c;

    assign c[0] = carryin;

    for (genvar g = 0; g < N_BLK; g++) begin : g_blk
        logic [BLK_W:0] r0;
        logic [BLK_W:0] r1;

        // Both candidate sums for this block; carry picks one.
        assign r0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
        assign r1 = r0 + (BLK_W+1)'(1);

        assign s[g*BLK_W +: BLK_W] = c[g] ? r1[BLK_W-1:0] : r0[BLK_W-1:0];
        assign c[g+1]              = c[g] ? r1[BLK_W]     : r0[BLK_W];
    end

    assign carryout = c[N_BLK];

endmodule

// File: rtl/spmv_row_accumulator.sv
// CSR SpMV row accumulator: sums a stream of per-nonzero products into one
// result per row (empty rows included) and hands results out on valid/ready.
// Optional feature macro: ROW_ACC_SAT_EN (saturate row sums at 16'hFFFF once
// an addition in the row has overflowed).
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      product beat valid
//   in_ready      beat can be accepted (state==S_ACC | out_ready)
//   in_data       unsigned product
//   in_last       beat closes the current row
//   in_empty_row  beat marks an empty row (in_data/in_last ignored)
//   out_valid     row result valid
//   out_ready     consumer accepts the result
//   out_data      row sum
//   out_row       row index of out_data
//   out_ovf       an addition in this row carried out
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int unsigned DATA_W = SPMV_DATA_W,
    parameter int unsigned ROW_W  = SPMV_ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_empty_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_ovf
);

    // The adder is a fixed 16-bit block; reject any other width at elaboration.
    if (DATA_W != 16) begin : g_bad_width
        $error("spmv_row_accumulator: DATA_W must be 16");
    end

    acc_state_t        state;
    acc_state_t        state_next;
    logic [DATA_W-1:0] acc;
    logic              ovf_acc;
    logic [ROW_W-1:0]  row_cnt;

    logic [15:0]       add_s;
    logic              add_co;
    logic              row_ovf;
    logic [DATA_W-1:0] row_sum;

    logic              in_xfer;
    logic              beat_acc;
    logic              beat_last;
    logic              beat_empty;

    carry_select_adder u_add (
        .a        (acc),
        .b        (in_data),
        .carryin  (1'b0),
        .s        (add_s),
        .carryout (add_co)
    );

    assign row_ovf = ovf_acc | add_co;

`ifdef ROW_ACC_SAT_EN
    // Clamp for the rest of the row once any addition has overflowed.
    assign row_sum = row_ovf ? {DATA_W{1'b1}} : add_s;
`else
    assign row_sum = add_s;
`endif

    // Single-stage output register; pass-through when drained this cycle.
    assign in_ready  = (state == S_ACC) | out_ready;
    assign out_valid = (state == S_OUT);

    assign in_xfer    = in_valid & in_ready;
    assign beat_empty = in_xfer & in_empty_row;
    assign beat_last  = in_xfer & ~in_empty_row & in_last;
    assign beat_acc   = in_xfer & ~in_empty_row & ~in_last;

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_ACC: begin
                if (beat_last | beat_empty) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = (beat_last | beat_empty) ? S_OUT : S_ACC;
                end
            end
            default: state_next = S_ACC;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_ACC;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            row_cnt  <= '0;
            out_data <= '0;
            out_row  <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_next;
            if (beat_acc) begin
                acc     <= row_sum;
                ovf_acc <= row_ovf;
            end
            if (beat_last) begin
                out_data <= row_sum;
                out_ovf  <= row_ovf;
                out_row  <= row_cnt;
                acc      <= '0;
                ovf_acc  <= 1'b0;
                row_cnt  <= row_cnt + ROW_W'(1);
            end
            // Empty row leaves any accumulator contents untouched.
            if (beat_empty) begin
                out_data <= '0;
                out_ovf  <= 1'b0;
                out_row  <= row_cnt;
                row_cnt  <= row_cnt + ROW_W'(1);
            end
        end
    end

endmodule
